// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory port arbiter:
//   - address/data widths of the 256 x 8 unified memory
//   - arbiter FSM state encoding
//   - requester (owner) encoding
//   - other_owner(): the requester that is not the given one
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// ---------------------------------------------------------------------------
// mem_arb_rr
// Two-way round-robin grant between instruction fetch and data access.
// Purely combinational; the last-grant state lives in the parent.
//
// Ports:
//   if_req_i      fetch request
//   d_req_i       data request
//   last_grant_i  requester granted most recently
//   grant_valid_o at least one request is pending
//   grant_o       requester to serve (meaningful only with grant_valid_o)
// ---------------------------------------------------------------------------
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  owner_e last_grant_i,
    output logic   grant_valid_o,
    output owner_e grant_o
);

    always_comb begin
        grant_valid_o = if_req_i | d_req_i;
        grant_o       = OWN_FETCH;
        if (if_req_i && d_req_i) begin
            // Tie: the requester that did not win last time goes first.
            grant_o = other_owner(last_grant_i);
        end else if (d_req_i) begin
            grant_o = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Sequencing controller and 2-way arbiter for the single-ported 256 x 8
// unified memory shared by instruction fetch and data load/store.
//
// Parameters:
//   READ_LAT  cycles from mem_re high to mem_rdata valid (legal 1..4)
//   CNT_W     width of the saturating conflict counter
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req/if_addr                     fetch request (held until if_ack)
//   if_ack/if_rdata                    fetch done pulse + instruction byte
//   d_req/d_we/d_addr/d_wdata          data request (held until d_ack)
//   d_ack/d_rdata                      data done pulse + load data
//   mem_addr/mem_re/mem_we/mem_wdata   registered memory controls
//   mem_rdata                          memory read data
//   busy                               FSM not in IDLE
//   owner                              current or last grant (0 fetch, 1 data)
//   conflict_cnt                       saturating count of requester-wait cycles
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              owner,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // WAIT is entered with READ_LAT-1 and captures data when it reaches 0,
    // which lines the capture edge up with the first valid mem_rdata cycle.
    localparam logic [1:0] WAIT_LOAD = 2'(READ_LAT - 1);

    arb_state_e        state_q;
    owner_e            owner_q;      // doubles as the round-robin last grant
    logic [1:0]        wcnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [CNT_W-1:0]  conflict_q;
    logic [CNT_W-1:0]  conflict_d;

    logic              gnt_valid;
    owner_e            gnt;
    logic              wait_evt;

    mem_arb_rr u_rr (
        .if_req_i      (if_req),
        .d_req_i       (d_req),
        .last_grant_i  (owner_q),
        .grant_valid_o (gnt_valid),
        .grant_o       (gnt)
    );

    // Strobes and acks default low every cycle, so each is a single-cycle
    // pulse raised only on the transition into ISSUE or DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            wcnt_q      <= '0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        owner_q <= gnt;
                        state_q <= ISSUE;
                        if (gnt == OWN_DATA) begin
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            mem_we_q    <= d_we;
                            mem_re_q    <= ~d_we;
                        end else begin
                            mem_addr_q  <= if_addr;
                            mem_re_q    <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    // mem_we_q still holds this cycle's strobe: it tells
                    // a write (done now) from a read (wait for data).
                    if (mem_we_q) begin
                        state_q  <= DONE;
                        if_ack_q <= (owner_q == OWN_FETCH);
                        d_ack_q  <= (owner_q == OWN_DATA);
                    end else begin
                        state_q  <= WAIT;
                        wcnt_q   <= WAIT_LOAD;
                    end
                end

                WAIT: begin
                    if (wcnt_q == 2'd0) begin
                        state_q <= DONE;
                        if (owner_q == OWN_DATA) begin
                            d_rdata_q <= mem_rdata;
                            d_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_ack_q   <= 1'b1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - 2'd1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A wait cycle: in IDLE only a tie leaves someone ungranted; while busy,
    // the non-owner is waiting whenever its request is up.
    always_comb begin
        wait_evt   = 1'b0;
        conflict_d = conflict_q;
        if (state_q == IDLE) begin
            wait_evt = if_req & d_req;
        end else begin
            wait_evt = (owner_q == OWN_DATA) ? if_req : d_req;
        end
        if (wait_evt && (conflict_q != '1)) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign if_ack       = if_ack_q;
    assign if_rdata     = if_rdata_q;
    assign d_ack        = d_ack_q;
    assign d_rdata      = d_rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_re       = mem_re_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != IDLE);
    assign owner        = owner_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiter instances share one clock:
//   inst 0: READ_LAT=1, CNT_W=8  (fetch/store/load, tie-break, alternation)
//   inst 1: READ_LAT=3, CNT_W=4  (reset during WAIT, counter saturation)
//   inst 2: READ_LAT=2, CNT_W=8  (longer read latency)
// Each instance has its own behavioural memory with a READ_LAT-deep read
// pipeline. Expected acks are queued when stimulus is driven and matched
// in order as acks appear.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NI = 3;

    function automatic int unsigned rl_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn      [NI];
    logic       if_req    [NI];
    logic [7:0] if_addr   [NI];
    logic       if_ack    [NI];
    logic [7:0] if_rdata  [NI];
    logic       d_req     [NI];
    logic       d_we      [NI];
    logic [7:0] d_addr    [NI];
    logic [7:0] d_wdata   [NI];
    logic       d_ack     [NI];
    logic [7:0] d_rdata   [NI];
    logic [7:0] mem_addr  [NI];
    logic       mem_re    [NI];
    logic       mem_we    [NI];
    logic [7:0] mem_wdata [NI];
    logic [7:0] mem_rdata [NI];
    logic       busy      [NI];
    logic       owner     [NI];
    logic [7:0] cc        [NI];

    logic [7:0] mem  [NI][256];
    logic [7:0] pipe [NI][4];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned GRL = rl_of(g);
        localparam int unsigned GCW = (g == 1) ? 4 : 8;
        logic [GCW-1:0] cc_w;

        mem_port_arbiter #(
            .READ_LAT (GRL),
            .CNT_W    (GCW)
        ) dut (
            .clk          (clk),
            .rst_n        (rstn[g]),
            .if_req       (if_req[g]),
            .if_addr      (if_addr[g]),
            .if_ack       (if_ack[g]),
            .if_rdata     (if_rdata[g]),
            .d_req        (d_req[g]),
            .d_we         (d_we[g]),
            .d_addr       (d_addr[g]),
            .d_wdata      (d_wdata[g]),
            .d_ack        (d_ack[g]),
            .d_rdata      (d_rdata[g]),
            .mem_addr     (mem_addr[g]),
            .mem_re       (mem_re[g]),
            .mem_we       (mem_we[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g]),
            .busy         (busy[g]),
            .owner        (owner[g]),
            .conflict_cnt (cc_w)
        );

        assign cc[g]        = 8'(cc_w);
        assign mem_rdata[g] = pipe[g][GRL-1];
    end

    // Memory models: write on mem_we, read data valid READ_LAT cycles after
    // mem_re; 0xEE marks a stage that carries no read.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (mem_we[i]) mem[i][mem_addr[i]] = mem_wdata[i];
            pipe[i][0] <= mem_re[i] ? mem[i][mem_addr[i]] : 8'hEE;
            for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         inst;
        logic       port;   // 0 fetch, 1 data
        logic       rd;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb[$];

    task automatic expect_ack(input int i, input logic port, input logic rd,
                              input logic [7:0] data, input int at);
        exp_t e;
        e.inst = i; e.port = port; e.rd = rd; e.data = data; e.at = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (mem_re[i] || mem_we[i])
                check("strobe_excl", {mem_re[i], mem_we[i]}, (mem_re[i] ? 2'b10 : 2'b01));
            if (if_ack[i] || d_ack[i]) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {if_ack[i], d_ack[i]}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("ack_inst", i, e.inst);
                    check("ack_port", {if_ack[i], d_ack[i]}, e.port ? 2'b01 : 2'b10);
                    check("ack_cycle", cyc, e.at);
                    if (e.rd)
                        check("ack_rdata", e.port ? d_rdata[i] : if_rdata[i], e.data);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the ack, at posedge+1, i.e. in the IDLE cycle.
    task automatic wait_ack(input int i, input logic port);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((port ? d_ack[i] : if_ack[i]) == 1'b1) break;
            n++;
            if (n > 40) begin
                check(port ? "d_ack_timeout" : "if_ack_timeout",
                      port ? d_ack[i] : if_ack[i], 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_txn(input int i, input logic [7:0] a);
        if_addr[i] = a;
        if_req[i]  = 1'b1;
        wait_ack(i, 1'b0);
        if_req[i]  = 1'b0;
    endtask

    task automatic data_txn(input int i, input logic we, input logic [7:0] a, input logic [7:0] wd);
        d_we[i]    = we;
        d_addr[i]  = a;
        d_wdata[i] = wd;
        d_req[i]   = 1'b1;
        wait_ack(i, 1'b1);
        d_req[i]   = 1'b0;
    endtask

    task automatic check_reset_state(input int i);
        check("rst_busy",    busy[i],      1'b0);
        check("rst_owner",   owner[i],     1'b0);
        check("rst_mem_re",  mem_re[i],    1'b0);
        check("rst_mem_we",  mem_we[i],    1'b0);
        check("rst_addr",    mem_addr[i],  8'h00);
        check("rst_wdata",   mem_wdata[i], 8'h00);
        check("rst_acks",    {if_ack[i], d_ack[i]}, 2'b00);
        check("rst_rdata",   {if_rdata[i], d_rdata[i]}, 16'h0000);
        check("rst_cc",      cc[i],        8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            rstn[i] = 1'b0; if_req[i] = 1'b0; if_addr[i] = '0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
            for (int a = 0; a < 256; a++) mem[i][a] = 8'h00;
        end
        mem[0][8'h10] = 8'hA5;
        mem[0][8'h41] = 8'h77;
        mem[1][8'h20] = 8'hC3;
        mem[1][8'h21] = 8'h3E;
        mem[2][8'h30] = 8'h9D;

        wait_cycles(3);
        for (int i = 0; i < NI; i++) check_reset_state(i);
        for (int i = 0; i < NI; i++) rstn[i] = 1'b1;
        wait_cycles(2);
        check_reset_state(0);

        // Fetch read alone: ISSUE at N+1, ack with data at N+3.
        n = cyc;
        expect_ack(0, 1'b0, 1'b1, 8'hA5, n + 3);
        if_addr[0] = 8'h10;
        if_req[0]  = 1'b1;
        @(negedge clk);
        check("t1_busy_at_req", busy[0], 1'b0);
        @(posedge clk); #1;
        if_addr[0] = 8'h55;            // post-grant change must be ignored
        @(negedge clk);
        check("t1_mem_re",   mem_re[0],   1'b1);
        check("t1_mem_addr", mem_addr[0], 8'h10);
        check("t1_busy",     busy[0],     1'b1);
        wait_ack(0, 1'b0);
        if_req[0] = 1'b0;

        // Store 0x3C to 0x80 (ack at N+2), then load it back.
        n = cyc;
        expect_ack(0, 1'b1, 1'b0, 8'h00, n + 2);
        d_we[0] = 1'b1; d_addr[0] = 8'h80; d_wdata[0] = 8'h3C; d_req[0] = 1'b1;
        @(negedge clk);
        check("t2_we_early", mem_we[0], 1'b0);
        @(negedge clk);
        check("t2_mem_we",    mem_we[0],    1'b1);
        check("t2_mem_wdata", mem_wdata[0], 8'h3C);
        check("t2_mem_addr",  mem_addr[0],  8'h80);
        wait_ack(0, 1'b1);
        d_req[0] = 1'b0;
        n = cyc;
        expect_ack(0, 1'b1, 1'b1, 8'h3C, n + 3);
        data_txn(0, 1'b0, 8'h80, 8'h00);
        wait_cycles(3);
        check("t2_d_rdata_hold",  d_rdata[0],  8'h3C);
        check("t2_if_rdata_hold", if_rdata[0], 8'hA5);

        // Reset inst 0 so the tie-break starts from last_grant = fetch.
        rstn[0] = 1'b0;
        #1;
        check("t3_rst_owner",  owner[0],   1'b0);
        check("t3_rst_drdata", d_rdata[0], 8'h00);
        wait_cycles(2);
        rstn[0] = 1'b1;
        wait_cycles(1);

        // Simultaneous store (data) and read (fetch): data first.
        n = cyc;
        expect_ack(0, 1'b1, 1'b0, 8'h00, n + 2);
        expect_ack(0, 1'b0, 1'b1, 8'h77, n + 6);
        fork
            data_txn(0, 1'b1, 8'h40, 8'h5A);
            fetch_txn(0, 8'h41);
            begin
                repeat (2) @(negedge clk);
                check("t3_owner_data", owner[0],  1'b1);
                check("t3_we_data",    mem_we[0], 1'b1);
                repeat (3) @(negedge clk);
                check("t3_owner_fetch", owner[0],    1'b0);
                check("t3_re_fetch",    mem_re[0],   1'b1);
                check("t3_addr_fetch",  mem_addr[0], 8'h41);
            end
        join
        @(negedge clk);
        check("t3_conflict", cc[0], 8'd3);
        check("t3_mem_written", mem[0][8'h40], 8'h5A);
        wait_cycles(1);

        // Both held for 16 cycles: data, fetch, data, fetch.
        n = cyc;
        expect_ack(0, 1'b1, 1'b1, 8'h77, n + 3);
        expect_ack(0, 1'b0, 1'b1, 8'hA5, n + 7);
        expect_ack(0, 1'b1, 1'b1, 8'h77, n + 11);
        expect_ack(0, 1'b0, 1'b1, 8'hA5, n + 15);
        d_we[0] = 1'b0; d_addr[0] = 8'h41; d_req[0] = 1'b1;
        if_addr[0] = 8'h10; if_req[0] = 1'b1;
        wait_cycles(16);
        d_req[0] = 1'b0; if_req[0] = 1'b0;
        @(negedge clk);
        check("t4_conflict", cc[0], 8'd19);
        wait_cycles(1);

        // Reset inst 1 (READ_LAT=3) in the middle of WAIT: no ack follows.
        if_addr[1] = 8'h20; if_req[1] = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_busy_wait", busy[1],     1'b1);
        check("t5_addr_wait", mem_addr[1], 8'h20);
        rstn[1] = 1'b0;
        #1;
        check_reset_state(1);
        if_req[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rstn[1] = 1'b1;
        wait_cycles(1);
        n = cyc;
        expect_ack(1, 1'b0, 1'b1, 8'hC3, n + 5);
        fetch_txn(1, 8'h20);

        // Saturation of the 4-bit counter, both requesters held 96 cycles.
        n = cyc;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) expect_ack(1, 1'b1, 1'b1, 8'h3E, n + 5 + 6 * k);
            else            expect_ack(1, 1'b0, 1'b1, 8'hC3, n + 5 + 6 * k);
        end
        d_we[1] = 1'b0; d_addr[1] = 8'h21; d_req[1] = 1'b1;
        if_addr[1] = 8'h20; if_req[1] = 1'b1;
        wait_cycles(10);
        @(negedge clk);
        check("t6_conflict_10", cc[1], 8'd10);
        repeat (86) @(posedge clk);
        #1;
        d_req[1] = 1'b0; if_req[1] = 1'b0;
        @(negedge clk);
        check("t6_conflict_sat", cc[1], 8'd15);
        wait_cycles(1);

        // READ_LAT=2: ack at N+4.
        n = cyc;
        expect_ack(2, 1'b0, 1'b1, 8'h9D, n + 4);
        fetch_txn(2, 8'h30);

        wait_cycles(3);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
